// File: rtl/sonar_pkg.sv
// Shared FSM state encoding and default timing constants for the sonar scheduler.
package sonar_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIGGER,
    ST_WAIT_RISE,
    ST_MEASURE,
    ST_SETTLE
  } sonar_state_e;

  localparam int DEF_NUM_SENSORS   = 4;
  localparam int DEF_CLK_PER_INCH  = 1470;
  localparam int DEF_TRIG_CYCLES   = 200;
  localparam int DEF_RISE_TIMEOUT  = 500_000;
  localparam int DEF_SETTLE_CYCLES = 10_000;

  localparam logic [7:0] INCH_MAX = 8'hFF;

endpackage

// File: rtl/sonar_width_counter.sv
// Echo pulse width to inches: down-counting prescaler feeding a saturating 8-bit inch count.
module sonar_width_counter
  import sonar_pkg::*;
#(
  parameter int CLK_PER_INCH = DEF_CLK_PER_INCH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  output logic [7:0] inches,
  output logic       sat
);

  localparam int PRE_W = (CLK_PER_INCH > 1) ? $clog2(CLK_PER_INCH) : 1;
  localparam logic [PRE_W-1:0] PRE_LOAD = PRE_W'(CLK_PER_INCH - 1);

  logic [PRE_W-1:0] pre_q;
  logic [7:0]       inch_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q  <= '0;
      inch_q <= '0;
    end else if (clr) begin
      pre_q  <= PRE_LOAD;
      inch_q <= '0;
    end else if (en && !sat) begin
      // Terminal count: one full inch of high time has elapsed.
      if (pre_q == '0) begin
        pre_q  <= PRE_LOAD;
        inch_q <= inch_q + 8'd1;
      end else begin
        pre_q <= pre_q - PRE_W'(1);
      end
    end
  end

  assign inches = inch_q;
  assign sat    = (inch_q == INCH_MAX);

endmodule

// File: rtl/sonar_scheduler.sv
// Round-robin ultrasonic ranging scheduler: triggers one sensor per slot and latches its echo width in inches.
//
// state        | meaning
// IDLE         | rx_en off, waiting for run
// TRIGGER      | rx_en[idx] high for TRIG_CYCLES
// WAIT_RISE    | waiting for echo rising edge, bounded by RISE_TIMEOUT
// MEASURE      | counting echo high time until falling edge or 255 inches
// SETTLE       | guard gap, then advance to the next sensor
module sonar_scheduler
  import sonar_pkg::*;
#(
  parameter  int NUM_SENSORS   = DEF_NUM_SENSORS,
  parameter  int CLK_PER_INCH  = DEF_CLK_PER_INCH,
  parameter  int TRIG_CYCLES   = DEF_TRIG_CYCLES,
  parameter  int RISE_TIMEOUT  = DEF_RISE_TIMEOUT,
  parameter  int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  localparam int IDX_W         = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run,
  input  logic [NUM_SENSORS-1:0]   pwm_in,
  output logic [NUM_SENSORS-1:0]   rx_en,
  output logic [8*NUM_SENSORS-1:0] distance,
  output logic                     sample_valid,
  output logic [IDX_W-1:0]         sample_idx,
  output logic [NUM_SENSORS-1:0]   timeout,
  output logic                     busy
);

  sonar_state_e state_q;

  logic [NUM_SENSORS-1:0]   sync1_q, sync2_q, prev_q;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [31:0]              timer_q;
  logic [NUM_SENSORS-1:0]   rx_en_q, timeout_q;
  logic [8*NUM_SENSORS-1:0] dist_q;
  logic                     valid_q;
  logic [IDX_W-1:0]         sidx_q;

  logic       sel_now, sel_prev, rise, fall;
  logic       cnt_clr, cnt_en, cnt_sat;
  logic [7:0] inches;

  assign sel_now  = sync2_q[idx_q];
  assign sel_prev = prev_q[idx_q];
  assign rise     = sel_now & ~sel_prev;
  assign fall     = ~sel_now & sel_prev;

  assign idx_d = (idx_q == IDX_W'(NUM_SENSORS - 1)) ? '0 : idx_q + IDX_W'(1);

  // The rise cycle itself is counted so the inch count covers the full high time.
  assign cnt_clr = !((state_q == ST_MEASURE) ||
                     (((state_q == ST_TRIGGER) || (state_q == ST_WAIT_RISE)) && rise));
  assign cnt_en  = sel_now & ~cnt_clr;

  sonar_width_counter #(
    .CLK_PER_INCH(CLK_PER_INCH)
  ) u_width_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .inches(inches),
    .sat   (cnt_sat)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      idx_q     <= '0;
      timer_q   <= '0;
      rx_en_q   <= '0;
      timeout_q <= '0;
      dist_q    <= '0;
      valid_q   <= 1'b0;
      sidx_q    <= '0;
    end else begin
      sync1_q <= pwm_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (run) begin
            state_q <= ST_TRIGGER;
            rx_en_q <= NUM_SENSORS'(1) << idx_q;
            timer_q <= 32'(TRIG_CYCLES - 1);
          end
        end
        ST_TRIGGER: begin
          if (rise) begin
            state_q <= ST_MEASURE;
            rx_en_q <= '0;
            timer_q <= '0;
          end else if (timer_q == '0) begin
            state_q <= ST_WAIT_RISE;
            rx_en_q <= '0;
            timer_q <= 32'(RISE_TIMEOUT - 1);
          end else begin
            timer_q <= timer_q - 32'd1;
          end
        end
        ST_WAIT_RISE: begin
          if (rise) begin
            state_q <= ST_MEASURE;
            timer_q <= '0;
          end else if (timer_q == '0) begin
            state_q            <= ST_SETTLE;
            timeout_q[idx_q]   <= 1'b1;
            valid_q            <= 1'b1;
            sidx_q             <= idx_q;
            timer_q            <= 32'(SETTLE_CYCLES - 1);
          end else begin
            timer_q <= timer_q - 32'd1;
          end
        end
        ST_MEASURE: begin
          if (fall || cnt_sat) begin
            state_q               <= ST_SETTLE;
            dist_q[8*idx_q +: 8]  <= inches;
            timeout_q[idx_q]      <= 1'b0;
            valid_q               <= 1'b1;
            sidx_q                <= idx_q;
            timer_q               <= 32'(SETTLE_CYCLES - 1);
          end
        end
        ST_SETTLE: begin
          if (timer_q == '0) begin
            idx_q <= idx_d;
            if (run) begin
              state_q <= ST_TRIGGER;
              rx_en_q <= NUM_SENSORS'(1) << idx_d;
              timer_q <= 32'(TRIG_CYCLES - 1);
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            timer_q <= timer_q - 32'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          rx_en_q <= '0;
        end
      endcase
    end
  end

  assign rx_en        = rx_en_q;
  assign distance     = dist_q;
  assign sample_valid = valid_q;
  assign sample_idx   = sidx_q;
  assign timeout      = timeout_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sonar_scheduler.sv
// Self-checking bench for sonar_scheduler with short timing parameters and a per-sensor result model.
module tb_sonar_scheduler;

  localparam int N      = 4;
  localparam int CPI    = 10;
  localparam int TRIG   = 8;
  localparam int RT     = 400;
  localparam int SETTLE = 20;

  logic           clk = 1'b0;
  logic           reset;
  logic           run;
  logic [N-1:0]   pwm_in;
  logic [N-1:0]   rx_en;
  logic [8*N-1:0] distance;
  logic           sample_valid;
  logic [1:0]     sample_idx;
  logic [N-1:0]   timeout;
  logic           busy;

  int n_cmp = 0;
  int n_bad = 0;

  int model_dist[N];
  bit model_to[N];
  int model_next;

  always #5 clk = ~clk;

  sonar_scheduler #(
    .NUM_SENSORS  (N),
    .CLK_PER_INCH (CPI),
    .TRIG_CYCLES  (TRIG),
    .RISE_TIMEOUT (RT),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .pwm_in      (pwm_in),
    .rx_en       (rx_en),
    .distance    (distance),
    .sample_valid(sample_valid),
    .sample_idx  (sample_idx),
    .timeout     (timeout),
    .busy        (busy)
  );

  function automatic logic [8*N-1:0] exp_dist();
    logic [8*N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[8*i +: 8] = 8'(model_dist[i]);
    return v;
  endfunction

  function automatic logic [N-1:0] exp_to();
    logic [N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i] = model_to[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      model_dist[i] = 0;
      model_to[i]   = 1'b0;
    end
    model_next = 0;
  endtask

  // One ranging slot for sensor s: echo starts d cycles after trigger end, lasts w cycles.
  task automatic run_slot(input int s, input int d, input int w, input bit silent, input bit drop_run);
    logic [N-1:0] oh;
    int k;
    int trig_len;
    int exp_in;
    bit rx_bad;
    bit got;
    oh     = N'(1) << s;
    rx_bad = 1'b0;
    got    = 1'b0;
    k      = 0;
    while (rx_en === '0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (rx_en !== oh) begin
      $display("FAIL trigger_sel: rx_en=%b required %b", rx_en, oh);
      n_bad++;
      return;
    end
    n_cmp++;
    if (busy !== 1'b1) begin
      $display("FAIL busy_in_slot: busy=%b required 1", busy);
      n_bad++;
    end
    trig_len = 0;
    while (rx_en === oh && trig_len < 10 * TRIG) begin
      @(negedge clk);
      trig_len++;
    end
    n_cmp++;
    if (trig_len != TRIG) begin
      $display("FAIL trig_len: got %0d cycles required %0d", trig_len, TRIG);
      n_bad++;
    end
    k = 0;
    while (k < d + w + RT + 100) begin
      if (rx_en !== '0) rx_bad = 1'b1;
      if (sample_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (!silent && k == d)     pwm_in[s] = 1'b1;
      if (!silent && k == d + w) pwm_in[s] = 1'b0;
      if (drop_run && k == d + 5) run = 1'b0;
      @(negedge clk);
      k++;
    end
    pwm_in[s] = 1'b0;
    n_cmp++;
    if (!got) begin
      $display("FAIL sample_valid_wait: no sample_valid within %0d cycles for sensor %0d", k, s);
      n_bad++;
      return;
    end
    if (silent) begin
      model_to[s] = 1'b1;
    end else begin
      exp_in = w / CPI;
      if (exp_in > 255) exp_in = 255;
      model_dist[s] = exp_in;
      model_to[s]   = 1'b0;
    end
    n_cmp++;
    if (sample_idx !== 2'(s)) begin
      $display("FAIL sample_idx: got %0d required %0d", sample_idx, s);
      n_bad++;
    end
    n_cmp++;
    if (distance !== exp_dist()) begin
      $display("FAIL distance: got %h required %h (sensor %0d, w=%0d)", distance, exp_dist(), s, w);
      n_bad++;
    end
    n_cmp++;
    if (timeout !== exp_to()) begin
      $display("FAIL timeout_bits: got %b required %b", timeout, exp_to());
      n_bad++;
    end
    n_cmp++;
    if (rx_bad !== 1'b0) begin
      $display("FAIL rx_en_quiet: rx_en active after trigger, flag %b required 0", rx_bad);
      n_bad++;
    end
    if (silent) begin
      n_cmp++;
      if (k < RT || k > RT + 2) begin
        $display("FAIL timeout_latency: got %0d cycles required %0d..%0d", k, RT, RT + 2);
        n_bad++;
      end
    end
    if (!silent && (w / CPI) > 255) begin
      n_cmp++;
      if (k >= d + w) begin
        $display("FAIL sat_early_end: slot ended at %0d required before %0d", k, d + w);
        n_bad++;
      end
    end
    @(negedge clk);
    n_cmp++;
    if (sample_valid !== 1'b0) begin
      $display("FAIL valid_one_cycle: sample_valid=%b required 0", sample_valid);
      n_bad++;
    end
    model_next = (s + 1) % N;
  endtask

  task automatic random_slot();
    int w;
    w = int'($urandom_range(0, 30)) * CPI + int'($urandom_range(0, CPI - 1));
    if (w == 0) w = 1;
    run_slot(model_next, int'($urandom_range(0, 50)), w, 1'b0, 1'b0);
  endtask

  task automatic advance_to(input int target);
    int guard;
    guard = 0;
    while (model_next != target && guard < N) begin
      random_slot();
      guard++;
    end
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    run    = 1'b1;
    pwm_in = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (rx_en !== '0)        begin $display("FAIL reset_rx_en: got %b required 0", rx_en); n_bad++; end
    n_cmp++; if (distance !== '0)     begin $display("FAIL reset_distance: got %h required 0", distance); n_bad++; end
    n_cmp++; if (timeout !== '0)      begin $display("FAIL reset_timeout: got %b required 0", timeout); n_bad++; end
    n_cmp++; if (sample_valid !== 1'b0) begin $display("FAIL reset_valid: got %b required 0", sample_valid); n_bad++; end
    n_cmp++; if (sample_idx !== '0)   begin $display("FAIL reset_idx: got %0d required 0", sample_idx); n_bad++; end
    n_cmp++; if (busy !== 1'b0)       begin $display("FAIL reset_busy: got %b required 0", busy); n_bad++; end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    run = 1'b1;
    run_slot(0, 7, 3 * CPI, 1'b0, 1'b0);
  endtask

  task automatic test_round_robin();
    int inch[4];
    inch = '{1, 2, 5, 9};
    advance_to(0);
    for (int i = 0; i < N; i++)
      run_slot(i, int'($urandom_range(0, 40)), inch[i] * CPI + int'($urandom_range(0, CPI - 1)), 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    advance_to(2);
    run_slot(2, 0, 0, 1'b1, 1'b0);
    advance_to(2);
    run_slot(2, 12, 6 * CPI + 4, 1'b0, 1'b0);
  endtask

  task automatic test_saturation();
    run_slot(model_next, 3, 300 * CPI, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) random_slot();
  endtask

  task automatic test_run_drop();
    bit rx_bad;
    advance_to(1);
    run_slot(1, 10, 4 * CPI + 3, 1'b0, 1'b1);
    rx_bad = 1'b0;
    repeat (SETTLE + 10) begin
      @(negedge clk);
      if (rx_en !== '0) rx_bad = 1'b1;
    end
    n_cmp++; if (busy !== 1'b0)   begin $display("FAIL run_drop_idle: busy=%b required 0", busy); n_bad++; end
    n_cmp++; if (rx_bad !== 1'b0) begin $display("FAIL run_drop_rx_en: retrigger flag %b required 0", rx_bad); n_bad++; end
    run = 1'b1;
    run_slot(2, 5, 2 * CPI + 1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_measure();
    int s;
    int k;
    s = model_next;
    k = 0;
    while (rx_en === '0 && k < 2000) begin @(negedge clk); k++; end
    k = 0;
    while (rx_en !== '0 && k < 2000) begin @(negedge clk); k++; end
    pwm_in[s] = 1'b1;
    repeat (3 * CPI) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin $display("FAIL busy_measure: got %b required 1", busy); n_bad++; end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (rx_en !== '0)          begin $display("FAIL mid_reset_rx_en: got %b required 0", rx_en); n_bad++; end
    n_cmp++; if (distance !== '0)       begin $display("FAIL mid_reset_distance: got %h required 0", distance); n_bad++; end
    n_cmp++; if (timeout !== '0)        begin $display("FAIL mid_reset_timeout: got %b required 0", timeout); n_bad++; end
    n_cmp++; if (sample_valid !== 1'b0) begin $display("FAIL mid_reset_valid: got %b required 0", sample_valid); n_bad++; end
    n_cmp++; if (sample_idx !== '0)     begin $display("FAIL mid_reset_idx: got %0d required 0", sample_idx); n_bad++; end
    n_cmp++; if (busy !== 1'b0)         begin $display("FAIL mid_reset_busy: got %b required 0", busy); n_bad++; end
    pwm_in[s] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    run_slot(0, 4, 7 * CPI + 2, 1'b0, 1'b0);
  endtask

  initial begin
    reset  = 1'b1;
    run    = 1'b0;
    pwm_in = '0;
    model_reset();
    test_reset();
    test_basic();
    test_round_robin();
    test_timeout();
    test_saturation();
    test_random();
    test_run_drop();
    test_reset_mid_measure();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
